// File: rtl/accum_frame_ctrl_if.sv
// Bundle of the three buses the frame controller sits between: the upstream
// sample stream, the accumulator datapath port and the downstream result stream.
// "master" is the controller's view, "slave" is the surrounding environment.
interface accum_frame_ctrl_if #(
   parameter int PAR_FACTOR = 4,
   parameter int DATA_WIDTH = 4,
   parameter int ACC_WIDTH  = 8
);
   // upstream sample stream
   logic                               s_valid;
   logic                               s_ready;
   logic [PAR_FACTOR*DATA_WIDTH-1:0]   s_data;

   // accumulator datapath
   logic                               acc_clr;
   logic                               acc_en;
   logic [PAR_FACTOR*DATA_WIDTH-1:0]   acc_data;
   logic [ACC_WIDTH-1:0]               acc_result;
   logic                               acc_ovf;

   // downstream result stream
   logic                               m_valid;
   logic                               m_ready;
   logic [ACC_WIDTH-1:0]               m_data;
   logic                               m_ovf;

   modport master (
      input  s_valid, s_data, acc_result, acc_ovf, m_ready,
      output s_ready, acc_clr, acc_en, acc_data, m_valid, m_data, m_ovf
   );

   modport slave (
      output s_valid, s_data, acc_result, acc_ovf, m_ready,
      input  s_ready, acc_clr, acc_en, acc_data, m_valid, m_data, m_ovf
   );
endinterface

// File: rtl/accum_frame_ctrl.sv
// Frame sequencer for the parallel accumulator: clear, admit frame_len beats,
// flush the datapath pipeline, then hold the captured sum until taken downstream.
module accum_frame_ctrl #(
   parameter int PAR_FACTOR = 4,
   parameter int DATA_WIDTH = 4,
   parameter int ACC_WIDTH  = 8,
   parameter int LEN_WIDTH  = 8,
   parameter int DP_LATENCY = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [LEN_WIDTH-1:0] frame_len,
   input  logic                 abort,
   accum_frame_ctrl_if.master   bus,
   output logic                 busy,
   output logic [LEN_WIDTH-1:0] beat_cnt
);

   localparam int LANE_BITS = PAR_FACTOR * DATA_WIDTH;
   localparam int DRAIN_W   = $clog2(DP_LATENCY + 1);

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      ACCUM,
      DRAIN,
      OUTPUT
   } state_t;

   state_t                 state_q;
   state_t                 state_d;

   logic [LEN_WIDTH-1:0]   len_q;
   logic [LEN_WIDTH-1:0]   cnt_q;
   logic [DRAIN_W-1:0]     drain_q;
   logic                   sticky_q;
   logic                   m_valid_q;
   logic [ACC_WIDTH-1:0]   m_data_q;
   logic                   m_ovf_q;

   logic                   s_ready_c;
   logic                   acc_clr_c;
   logic                   acc_en_c;
   logic [LANE_BITS-1:0]   acc_data_c;

   logic                   kill;
   logic                   accept;
   logic                   last_beat;
   logic                   drain_done;
   logic                   out_taken;
   logic                   frame_go;

   // Event decode shared by the FSM and the datapath registers.
   assign kill       = abort && (state_q != IDLE);
   assign accept     = (state_q == ACCUM) && bus.s_valid;
   assign last_beat  = accept && (cnt_q == (len_q - LEN_WIDTH'(1)));
   assign drain_done = (state_q == DRAIN) && (drain_q == DRAIN_W'(1));
   assign out_taken  = (state_q == OUTPUT) && bus.m_ready;
   // A new frame may launch from IDLE or straight out of a taken result.
   assign frame_go   = start && (frame_len != '0) && !kill &&
                       ((state_q == IDLE) || out_taken);

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and datapath/handshake controls; abort overrides everything.
   always_comb begin
      state_d    = state_q;
      s_ready_c  = 1'b0;
      acc_clr_c  = 1'b0;
      acc_en_c   = 1'b0;
      acc_data_c = '0;

      case (state_q)
         IDLE: begin
            if (frame_go) begin
               state_d = CLEAR;
            end
         end
         CLEAR: begin
            acc_clr_c = 1'b1;
            state_d   = ACCUM;
         end
         ACCUM: begin
            s_ready_c  = 1'b1;
            acc_en_c   = bus.s_valid;
            acc_data_c = bus.s_data;
            if (last_beat) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            // zero beats push the last real beat through the datapath pipeline
            acc_en_c = 1'b1;
            if (drain_done) begin
               state_d = OUTPUT;
            end
         end
         OUTPUT: begin
            if (out_taken) begin
               state_d = frame_go ? CLEAR : IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (kill) begin
         state_d = IDLE;
      end
   end

   // Frame length, latched only when a frame actually launches.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         len_q <= '0;
      end else if (frame_go) begin
         len_q <= frame_len;
      end
   end

   // Accepted-beat counter; holds its final value until the next frame or abort.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else if (kill || frame_go || (state_q == CLEAR)) begin
         cnt_q <= '0;
      end else if (accept) begin
         cnt_q <= cnt_q + LEN_WIDTH'(1);
      end
   end

   // Flush-cycle counter, armed by the last accepted beat.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         drain_q <= '0;
      end else if (last_beat) begin
         drain_q <= DRAIN_W'(DP_LATENCY);
      end else if (state_q == DRAIN) begin
         drain_q <= drain_q - DRAIN_W'(1);
      end
   end

   // Sticky overflow across the whole frame, so a transient pulse is not lost.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sticky_q <= 1'b0;
      end else if (state_q == CLEAR) begin
         sticky_q <= 1'b0;
      end else if ((state_q == ACCUM) || (state_q == DRAIN)) begin
         sticky_q <= sticky_q | bus.acc_ovf;
      end
   end

   // Result capture and output valid; abort discards a pending result.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_valid_q <= 1'b0;
         m_data_q  <= '0;
         m_ovf_q   <= 1'b0;
      end else if (kill) begin
         m_valid_q <= 1'b0;
      end else if (drain_done) begin
         m_valid_q <= 1'b1;
         m_data_q  <= bus.acc_result;
         m_ovf_q   <= sticky_q | bus.acc_ovf;
      end else if (out_taken) begin
         m_valid_q <= 1'b0;
      end
   end

   assign bus.s_ready  = s_ready_c;
   assign bus.acc_clr  = acc_clr_c;
   assign bus.acc_en   = acc_en_c;
   assign bus.acc_data = acc_data_c;
   assign bus.m_valid  = m_valid_q;
   assign bus.m_data   = m_data_q;
   assign bus.m_ovf    = m_ovf_q;
   assign busy         = (state_q != IDLE);
   assign beat_cnt     = cnt_q;

   // Input and output sides are never open at the same time.
   a_no_overlap : assert property (@(posedge clk) disable iff (!rst)
      !(s_ready_c && m_valid_q));

   // The clear pulse is always exactly one cycle wide.
   a_clr_single : assert property (@(posedge clk) disable iff (!rst)
      acc_clr_c |=> !acc_clr_c);

   // A stalled result stays put until taken or aborted.
   a_hold_result : assert property (@(posedge clk) disable iff (!rst)
      (m_valid_q && !bus.m_ready && !abort) |=> (m_valid_q && $stable(m_data_q) && $stable(m_ovf_q)));

endmodule

// File: tb/tb_accum_frame_ctrl.sv
// Directed bench for accum_frame_ctrl: a behavioural accumulator model closes the
// datapath loop, expected results are queued at stimulus time and a monitor
// compares them against each result handshake.
module tb_accum_frame_ctrl;

   localparam int PF  = 4;
   localparam int DW  = 4;
   localparam int AW  = 8;
   localparam int LW  = 8;
   localparam int LAT = 2;

   typedef struct {
      logic [AW-1:0] d;
      logic          o;
   } exp_t;

   logic          clk;
   logic          rst;
   logic          start;
   logic [LW-1:0] frame_len;
   logic          abort;
   logic          busy;
   logic [LW-1:0] beat_cnt;

   int   n_cmp;
   int   n_err;
   exp_t exp_q[$];

   // accumulator model state
   logic [AW-1:0] p1;
   logic [AW-1:0] acc;
   logic          carry_q;
   logic          ovf_force;

   accum_frame_ctrl_if #(.PAR_FACTOR(PF), .DATA_WIDTH(DW), .ACC_WIDTH(AW)) bus ();

   accum_frame_ctrl #(
      .PAR_FACTOR (PF),
      .DATA_WIDTH (DW),
      .ACC_WIDTH  (AW),
      .LEN_WIDTH  (LW),
      .DP_LATENCY (LAT)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .frame_len (frame_len),
      .abort     (abort),
      .bus       (bus),
      .busy      (busy),
      .beat_cnt  (beat_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [AW-1:0] lane_sum(input logic [PF*DW-1:0] v);
      logic [AW-1:0] s;
      s = '0;
      for (int i = 0; i < PF; i++) begin
         s = s + AW'(v[i*DW +: DW]);
      end
      return s;
   endfunction

   // Two-stage accumulator model: lane-sum register, then running sum with carry pulse.
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         p1      <= '0;
         acc     <= '0;
         carry_q <= 1'b0;
      end else if (bus.acc_clr) begin
         p1      <= '0;
         acc     <= '0;
         carry_q <= 1'b0;
      end else if (bus.acc_en) begin
         p1             <= lane_sum(bus.acc_data);
         {carry_q, acc} <= {1'b0, acc} + {1'b0, p1};
      end else begin
         carry_q <= 1'b0;
      end
   end

   assign bus.acc_result = acc;
   assign bus.acc_ovf    = carry_q | ovf_force;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Result monitor: every handshake must match the oldest queued expectation.
   always @(negedge clk) begin
      if (rst && bus.m_valid && bus.m_ready) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_result: got data 0x%0h ovf %0b, none expected",
                     bus.m_data, bus.m_ovf);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("m_data", 32'(bus.m_data), 32'(e.d));
            check("m_ovf", 32'(bus.m_ovf), 32'(e.o));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input logic [AW-1:0] d, input logic o);
      exp_t e;
      e.d = d;
      e.o = o;
      exp_q.push_back(e);
   endtask

   // Request a frame from IDLE; frame_len is then scrambled to prove it was latched.
   task automatic start_frame(input int len);
      start     = 1'b1;
      frame_len = LW'(len);
      tick();
      start     = 1'b0;
      frame_len = 8'hFF;
   endtask

   // Entered in CLEAR; feeds len beats, optionally with a gap after each one
   // and an injected overflow pulse on beat index inj.
   task automatic do_beats(input int len, input logic [PF*DW-1:0] data, input bit gap, input int inj);
      check("clr_pulse", 32'(bus.acc_clr), 32'd1);
      check("cnt_at_clear", 32'(beat_cnt), 32'd0);
      tick();
      for (int i = 0; i < len; i++) begin
         bus.s_valid = 1'b1;
         bus.s_data  = data;
         ovf_force   = (i == inj);
         #1;
         check("acc_en_beat", 32'(bus.acc_en), 32'd1);
         tick();
         ovf_force   = 1'b0;
         bus.s_valid = 1'b0;
         bus.s_data  = '0;
         if (gap && (i != len - 1)) begin
            #1;
            check("acc_en_gap", 32'(bus.acc_en), 32'd0);
            check("s_ready_gap", 32'(bus.s_ready), 32'd1);
            tick();
         end
      end
   endtask

   // Entered just after the last beat's edge; counts edges until m_valid rises.
   task automatic wait_result();
      int n;
      check("drain_en", 32'(bus.acc_en), 32'd1);
      check("drain_rdy", 32'(bus.s_ready), 32'd0);
      n = 0;
      while (!bus.m_valid && n < 20) begin
         tick();
         n++;
      end
      check("result_latency", 32'(n), 32'(LAT));
   endtask

   task automatic run_frame(input int len, input logic [PF*DW-1:0] data, input bit gap,
                            input int inj, input logic [AW-1:0] ed, input logic eo);
      push_exp(ed, eo);
      start_frame(len);
      do_beats(len, data, gap, inj);
      wait_result();
      check("beat_cnt_final", 32'(beat_cnt), 32'(len));
      tick();
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_m_valid", 32'(bus.m_valid), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      n_cmp       = 0;
      n_err       = 0;
      rst         = 1'b0;
      start       = 1'b0;
      frame_len   = '0;
      abort       = 1'b0;
      ovf_force   = 1'b0;
      bus.s_valid = 1'b0;
      bus.s_data  = '0;
      bus.m_ready = 1'b1;

      // reset state
      tick();
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_s_ready", 32'(bus.s_ready), 32'd0);
      check("rst_m_valid", 32'(bus.m_valid), 32'd0);
      check("rst_m_data", 32'(bus.m_data), 32'd0);
      check("rst_beat_cnt", 32'(beat_cnt), 32'd0);
      check("rst_acc_en", 32'(bus.acc_en), 32'd0);
      tick();
      rst = 1'b1;
      tick();

      // 3 beats of lanes=1 -> 12
      run_frame(3, 16'h1111, 1'b0, -1, 8'h0C, 1'b0);

      // 4 beats of lanes=2 with gaps -> 32
      run_frame(4, 16'h2222, 1'b1, -1, 8'h20, 1'b0);

      // stalled output, then back-to-back frame on the taking cycle
      bus.m_ready = 1'b0;
      push_exp(8'h18, 1'b0);
      start_frame(2);
      do_beats(2, 16'h3333, 1'b0, -1);
      wait_result();
      for (int i = 0; i < 5; i++) begin
         check("stall_m_valid", 32'(bus.m_valid), 32'd1);
         check("stall_m_data", 32'(bus.m_data), 32'h18);
         check("stall_s_ready", 32'(bus.s_ready), 32'd0);
         tick();
      end
      bus.m_ready = 1'b1;
      start       = 1'b1;
      frame_len   = 8'd2;
      push_exp(8'h08, 1'b0);
      tick();
      start     = 1'b0;
      frame_len = 8'hFF;
      check("b2b_busy", 32'(busy), 32'd1);
      do_beats(2, 16'h1111, 1'b0, -1);
      wait_result();
      tick();

      // wrap-around: 5 x 60 = 300 -> 0x2C with overflow
      run_frame(5, 16'hFFFF, 1'b0, -1, 8'h2C, 1'b1);

      // transient overflow mid-frame must stick to the result
      run_frame(3, 16'h1111, 1'b0, 1, 8'h0C, 1'b1);

      // abort after 2 of 4 beats
      start_frame(4);
      do_beats(2, 16'h1111, 1'b0, -1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_beat_cnt", 32'(beat_cnt), 32'd0);
      check("abort_m_valid", 32'(bus.m_valid), 32'd0);
      repeat (4) tick();
      check("abort_quiet", 32'(bus.m_valid), 32'd0);
      run_frame(2, 16'h1111, 1'b0, -1, 8'h08, 1'b0);

      // single-beat frame aborted while its result waits in OUTPUT
      bus.m_ready = 1'b0;
      start_frame(1);
      do_beats(1, 16'h1111, 1'b0, -1);
      wait_result();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      bus.m_ready = 1'b1;
      check("abort_out_valid", 32'(bus.m_valid), 32'd0);
      check("abort_out_busy", 32'(busy), 32'd0);

      // zero-length start is ignored
      start     = 1'b1;
      frame_len = 8'd0;
      tick();
      start = 1'b0;
      check("len0_busy", 32'(busy), 32'd0);
      check("len0_clr", 32'(bus.acc_clr), 32'd0);
      tick();
      check("len0_still_idle", 32'(busy), 32'd0);

      // asynchronous reset in the middle of DRAIN
      start_frame(2);
      do_beats(2, 16'h1111, 1'b0, -1);
      check("drain_busy", 32'(busy), 32'd1);
      #3;
      rst = 1'b0;
      #1;
      check("arst_busy", 32'(busy), 32'd0);
      check("arst_beat_cnt", 32'(beat_cnt), 32'd0);
      check("arst_acc_en", 32'(bus.acc_en), 32'd0);
      check("arst_m_valid", 32'(bus.m_valid), 32'd0);
      check("arst_m_data", 32'(bus.m_data), 32'd0);
      check("arst_m_ovf", 32'(bus.m_ovf), 32'd0);
      tick();
      rst = 1'b1;
      repeat (4) tick();

      check("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/accum_frame_ctrl.md
Name: accum_frame_ctrl

Overview:
- Frame sequencer for the parallel accumulator datapath (PAR_FACTOR lanes into one ACC_WIDTH sum).
- Per frame: clears the datapath, admits exactly frame_len input beats via a valid/ready handshake, flushes the datapath pipeline, then captures the total and its overflow flag.
- Presents the result on a valid/ready output port. Sits between the upstream sample source and the accumulator instance.

Parameters:
PAR_FACTOR, 4, lanes per beat
DATA_WIDTH, 4, bits per lane
ACC_WIDTH, 8, accumulator/result width
LEN_WIDTH, 8, width of frame_len and beat_cnt
DP_LATENCY, 2, flush cycles from last accepted beat to valid datapath result (>=1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  frame start request
frame_len  in  LEN_WIDTH  beats per frame, sampled on accepted start
abort  in  1  cancel current frame
s_valid  in  1  upstream beat valid
s_ready  out  1  controller accepts beat
s_data  in  PAR_FACTOR*DATA_WIDTH  lane data, lane0 in LSBs
acc_clr  out  1  synchronous clear to datapath
acc_en  out  1  datapath enable
acc_data  out  PAR_FACTOR*DATA_WIDTH  datapath lane inputs
acc_result  in  ACC_WIDTH  datapath sum
acc_ovf  in  1  datapath overflow
m_valid  out  1  result valid
m_ready  in  1  downstream accepts result
m_data  out  ACC_WIDTH  captured frame sum
m_ovf  out  1  overflow occurred during frame
busy  out  1  state != IDLE
beat_cnt  out  LEN_WIDTH  beats accepted in current frame

Behaviour:
- Reset (rst=0, async): state=IDLE. All outputs 0, including m_data, m_ovf, beat_cnt, the latched length and the sticky overflow flag.
- States: IDLE, CLEAR, ACCUM, DRAIN, OUTPUT.
- IDLE: s_ready=0, acc_en=0.
  - start=1 and frame_len!=0: latch frame_len, beat_cnt<=0, go to CLEAR.
  - start with frame_len==0: ignored, stay in IDLE.
- CLEAR (exactly 1 cycle): acc_clr=1, acc_en=0, sticky_ovf<=0; go to ACCUM.
- ACCUM: s_ready=1; acc_en=s_valid; acc_data=s_data (combinational).
  - Each accepted beat (s_valid&s_ready) increments beat_cnt.
  - Beat accepted while beat_cnt==len-1: go to DRAIN with drain counter=DP_LATENCY.
  - s_valid gaps: hold state, acc_en=0.
- DRAIN (DP_LATENCY cycles): s_ready=0; acc_en=1 with acc_data=0 (zero flush beats advance the datapath output register).
  - At the edge ending the last DRAIN cycle: m_data<=acc_result, m_ovf<=sticky_ovf|acc_ovf, m_valid<=1; go to OUTPUT.
- sticky_ovf ORs acc_ovf every cycle in ACCUM and DRAIN.
- OUTPUT: m_valid=1; m_data/m_ovf held stable until m_ready; s_ready=0.
  - On m_valid&m_ready: m_valid<=0 and go to IDLE.
  - If start=1 with frame_len!=0 in the same cycle, go directly to CLEAR (back-to-back frames).
- start is ignored in CLEAR, ACCUM and DRAIN.
- abort: from any non-IDLE state go to IDLE next edge; m_valid<=0, beat_cnt<=0, no result emitted.
  - Priority: abort > handshake/start.
  - Abort in OUTPUT discards the pending result.
- frame_len changes after start have no effect on the current frame.
- beat_cnt holds its final value (len) through DRAIN/OUTPUT; it clears only on reset, abort or CLEAR.
- busy=1 in every state except IDLE.
- Reset asserted mid-frame: immediate return to reset values; the datapath is cleared by its own reset.

Test Plan:
- frame_len=3, three back-to-back beats with all lanes=1, acc_result model sum=12 -> m_valid rises DP_LATENCY edges after the 3rd beat; m_data=0x0C, m_ovf=0, beat_cnt=3, one acc_clr pulse at frame start.
- frame_len=4 with s_valid toggling 1,0,1,0... (all lanes=2) -> exactly 4 beats accepted, acc_en low in gap cycles, m_data=0x20.
- m_ready held 0 for 5 cycles in OUTPUT -> m_valid, m_data stable and s_ready=0 throughout; handshake on cycle 6 with start=1 and frame_len=2 -> CLEAR on the next cycle, no IDLE cycle.
- All lanes=15, frame_len=5 (sum 300 > 255), acc_ovf pulses mid-frame -> m_ovf=1 even if acc_ovf is low at capture.
- abort after 2 of 4 beats -> IDLE next edge, m_valid never asserts, busy=0; the next frame starts with acc_clr and beat_cnt=0.
- start with frame_len=0 -> stays IDLE, busy=0. rst=0 asserted mid-DRAIN -> all outputs 0 immediately, without waiting for a clock edge.
